// File: rtl/rom_arb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | rom_arb_pkg : shared constants for the ROM port arbiter         |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
package rom_arb_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 32;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_READ = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | rr_arbiter2 : two-way round-robin pick, pointer held by parent  |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
module rr_arbiter2
    import rom_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       winner
);

    always_comb begin
        gnt    = 2'b00;
        winner = PORT_FETCH;
        case (req)
            2'b01: begin
                gnt    = 2'b01;
                winner = PORT_FETCH;
            end
            2'b10: begin
                gnt    = 2'b10;
                winner = PORT_DATA;
            end
            2'b11: begin
                // On a tie the port that did not win last time goes next
                winner = ~last;
                gnt    = last ? 2'b01 : 2'b10;
            end
            default: begin
                gnt    = 2'b00;
                winner = PORT_FETCH;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rom_port_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | rom_port_arbiter : shares one combinational ROM between fetch   |
// | and data ports with programmable wait states.   rev 1.0         |
// +-----------------------------------------------------------------+
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = 4096,
    parameter int RD_WAIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              flush0,
    output logic              gnt0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              rerr,
    output logic              busy,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    localparam logic [2:0] WAIT_INIT = 3'(RD_WAIT);

    logic [0:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic              owner;
    logic              last;
    logic              flushed;
    logic [2:0]        cnt;
    logic              in_range;
    logic [1:0]        arb_gnt;
    logic              arb_winner;
    logic              idle;
    logic              grant;

    rr_arbiter2 u_arb (
        .req    ({req1, req0}),
        .last   (last),
        .gnt    (arb_gnt),
        .winner (arb_winner)
    );

    assign idle     = (state == ST_IDLE);
    assign gnt0     = idle & ~rst & arb_gnt[0];
    assign gnt1     = idle & ~rst & arb_gnt[1];
    assign grant    = gnt0 | gnt1;
    assign busy     = ~idle;
    assign rom_addr = addr_q;

    generate
        if (longint'(DEPTH) >= (64'd1 << ADDR_W)) begin : g_full_range
            assign in_range = 1'b1;
        end else begin : g_part_range
            assign in_range = ({1'b0, addr_q} < (ADDR_W+1)'(DEPTH));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            owner   <= PORT_FETCH;
            last    <= PORT_DATA;
            cnt     <= 3'd0;
            flushed <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata   <= '0;
            rerr    <= 1'b0;
        end else begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        addr_q  <= arb_winner ? addr1 : addr0;
                        owner   <= arb_winner;
                        last    <= arb_winner;
                        cnt     <= WAIT_INIT;
                        flushed <= flush0 & (arb_winner == PORT_FETCH);
                        state   <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (flush0) begin
                        flushed <= 1'b1;
                    end
                    if (cnt != 3'd0) begin
                        cnt <= cnt - 3'd1;
                    end else begin
                        if (in_range) begin
                            rdata <= rom_data;
                            rerr  <= 1'b0;
                        end else begin
                            rdata <= '0;
                            rerr  <= 1'b1;
                        end
                        // A flush seen on the capture edge itself still cancels
                        if (owner == PORT_DATA) begin
                            rvalid1 <= 1'b1;
                        end else begin
                            rvalid0 <= ~(flushed | flush0);
                        end
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rom_port_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_rom_port_arbiter : directed self-checking bench               |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_rom_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, flush0 = 1'b0;
    logic [11:0] addr0 = '0, addr1 = '0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Instance A: RD_WAIT=0, DEPTH=1024
    logic        gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, rerr_a, busy_a;
    logic [31:0] rdata_a, rom_data_a;
    logic [11:0] rom_addr_a;
    // Instance B: RD_WAIT=3, DEPTH=4096
    logic        gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, rerr_b, busy_b;
    logic [31:0] rdata_b, rom_data_b;
    logic [11:0] rom_addr_b;
    // Instance C: RD_WAIT=5, DEPTH=4096
    logic        gnt0_c, gnt1_c, rvalid0_c, rvalid1_c, rerr_c, busy_c;
    logic [31:0] rdata_c, rom_data_c;
    logic [11:0] rom_addr_c;

    function automatic logic [31:0] rom(input logic [11:0] a);
        if (a == 12'h010) return 32'h0050_0093;
        return {20'hC0DE0, a};
    endfunction

    assign rom_data_a = rom(rom_addr_a);
    assign rom_data_b = rom(rom_addr_b);
    assign rom_data_c = rom(rom_addr_c);

    rom_port_arbiter #(.ADDR_W(12), .DATA_W(32), .DEPTH(1024), .RD_WAIT(0)) dut_a (
        .clk(clk), .rst(rst), .req0(req0), .addr0(addr0), .flush0(flush0),
        .gnt0(gnt0_a), .rvalid0(rvalid0_a), .req1(req1), .addr1(addr1),
        .gnt1(gnt1_a), .rvalid1(rvalid1_a), .rdata(rdata_a), .rerr(rerr_a),
        .busy(busy_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a));

    rom_port_arbiter #(.ADDR_W(12), .DATA_W(32), .DEPTH(4096), .RD_WAIT(3)) dut_b (
        .clk(clk), .rst(rst), .req0(req0), .addr0(addr0), .flush0(flush0),
        .gnt0(gnt0_b), .rvalid0(rvalid0_b), .req1(req1), .addr1(addr1),
        .gnt1(gnt1_b), .rvalid1(rvalid1_b), .rdata(rdata_b), .rerr(rerr_b),
        .busy(busy_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b));

    rom_port_arbiter #(.ADDR_W(12), .DATA_W(32), .DEPTH(4096), .RD_WAIT(5)) dut_c (
        .clk(clk), .rst(rst), .req0(req0), .addr0(addr0), .flush0(flush0),
        .gnt0(gnt0_c), .rvalid0(rvalid0_c), .req1(req1), .addr1(addr1),
        .gnt1(gnt1_c), .rvalid1(rvalid1_c), .rdata(rdata_c), .rerr(rerr_c),
        .busy(busy_c), .rom_addr(rom_addr_c), .rom_data(rom_data_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        // Reset values, grants gated while reset is high
        req0 = 1'b1;
        req1 = 1'b1;
        step();
        chk("rst_gnt0", 32'(gnt0_a), 32'd0);
        chk("rst_gnt1", 32'(gnt1_a), 32'd0);
        chk("rst_rvalid", 32'({rvalid0_a, rvalid1_a}), 32'd0);
        chk("rst_rdata", rdata_a, 32'd0);
        chk("rst_rerr", 32'(rerr_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr_a), 32'd0);
        req0 = 1'b0;
        req1 = 1'b0;
        rst  = 1'b0;
        step();

        // Single fetch, RD_WAIT=0
        req0  = 1'b1;
        addr0 = 12'h010;
        #1;
        chk("fetch_gnt0", 32'(gnt0_a), 32'd1);
        chk("fetch_gnt1", 32'(gnt1_a), 32'd0);
        step();
        req0 = 1'b0;
        #1;
        chk("fetch_busy", 32'(busy_a), 32'd1);
        chk("fetch_rom_addr", 32'(rom_addr_a), 32'h010);
        chk("fetch_no_early_rvalid", 32'(rvalid0_a), 32'd0);
        step();
        chk("fetch_rvalid0", 32'(rvalid0_a), 32'd1);
        chk("fetch_rvalid1", 32'(rvalid1_a), 32'd0);
        chk("fetch_rdata", rdata_a, 32'h0050_0093);
        chk("fetch_rerr", 32'(rerr_a), 32'd0);
        chk("fetch_busy_done", 32'(busy_a), 32'd0);
        step();
        chk("fetch_rvalid_pulse", 32'(rvalid0_a), 32'd0);
        chk("fetch_rom_addr_hold", 32'(rom_addr_a), 32'h010);

        // Tie after reset: grants alternate 0,1,0,1
        pulse_reset();
        req0  = 1'b1;
        req1  = 1'b1;
        addr0 = 12'h020;
        addr1 = 12'h030;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("tie_gnt0_%0d", k), 32'(gnt0_a), 32'(k % 2 == 0));
            chk($sformatf("tie_gnt1_%0d", k), 32'(gnt1_a), 32'(k % 2 == 1));
            if (k > 0) begin
                chk($sformatf("tie_rv0_%0d", k), 32'(rvalid0_a), 32'(k % 2 == 1));
                chk($sformatf("tie_rv1_%0d", k), 32'(rvalid1_a), 32'(k % 2 == 0));
                chk($sformatf("tie_rdata_%0d", k), rdata_a,
                    (k % 2 == 1) ? 32'hC0DE_0020 : 32'hC0DE_0030);
            end
            step();
            chk($sformatf("tie_nogrant_%0d", k), 32'({gnt0_a, gnt1_a}), 32'd0);
            step();
        end
        req0 = 1'b0;
        req1 = 1'b0;
        #1;
        chk("tie_last_rv1", 32'(rvalid1_a), 32'd1);
        chk("tie_last_rdata", rdata_a, 32'hC0DE_0030);
        step();

        // Out of range with DEPTH=1024, then the last legal word
        req1  = 1'b1;
        addr1 = 12'h400;
        #1;
        chk("oor_gnt1", 32'(gnt1_a), 32'd1);
        step();
        addr1 = 12'h3FF;
        step();
        chk("oor_rvalid1", 32'(rvalid1_a), 32'd1);
        chk("oor_rdata", rdata_a, 32'd0);
        chk("oor_rerr", 32'(rerr_a), 32'd1);
        chk("oor_back2back_gnt1", 32'(gnt1_a), 32'd1);
        step();
        req1 = 1'b0;
        step();
        chk("inr_rvalid1", 32'(rvalid1_a), 32'd1);
        chk("inr_rerr", 32'(rerr_a), 32'd0);
        chk("inr_rdata", rdata_a, 32'hC0DE_03FF);
        step();
        chk("inr_rdata_hold", rdata_a, 32'hC0DE_03FF);
        chk("inr_rvalid_pulse", 32'(rvalid1_a), 32'd0);

        // Flush of a port-0 access while port 1 waits
        req0  = 1'b1;
        addr0 = 12'h010;
        req1  = 1'b1;
        addr1 = 12'h040;
        #1;
        chk("flush_gnt0", 32'(gnt0_a), 32'd1);
        step();
        req0   = 1'b0;
        flush0 = 1'b1;
        #1;
        chk("flush_read_gnt1", 32'(gnt1_a), 32'd0);
        step();
        flush0 = 1'b0;
        #1;
        chk("flush_rvalid0", 32'(rvalid0_a), 32'd0);
        chk("flush_busy", 32'(busy_a), 32'd0);
        chk("flush_rdata_updated", rdata_a, 32'h0050_0093);
        chk("flush_gnt1", 32'(gnt1_a), 32'd1);
        step();
        req1 = 1'b0;
        flush0 = 1'b1;
        step();
        flush0 = 1'b0;
        #1;
        chk("flush_p1_rvalid1", 32'(rvalid1_a), 32'd1);
        chk("flush_p1_rdata", rdata_a, 32'hC0DE_0040);
        step();

        // Wait states, RD_WAIT=3 (instance B)
        pulse_reset();
        req1  = 1'b1;
        addr1 = 12'h7FF;
        #1;
        chk("wait_gnt1", 32'(gnt1_b), 32'd1);
        step();
        req1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("wait_busy_%0d", i), 32'(busy_b), 32'd1);
            chk($sformatf("wait_norv_%0d", i), 32'(rvalid1_b), 32'd0);
            step();
        end
        chk("wait_rvalid1", 32'(rvalid1_b), 32'd1);
        chk("wait_rdata", rdata_b, 32'hC0DE_07FF);
        chk("wait_busy_done", 32'(busy_b), 32'd0);
        req1  = 1'b1;
        addr1 = 12'hFFF;
        #1;
        chk("full_gnt1", 32'(gnt1_b), 32'd1);
        step();
        req1 = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("full_rvalid1", 32'(rvalid1_b), 32'd1);
        chk("full_rerr", 32'(rerr_b), 32'd0);
        chk("full_rdata", rdata_b, 32'hC0DE_0FFF);

        // Reset mid-READ, RD_WAIT=5 (instance C)
        pulse_reset();
        req0  = 1'b1;
        req1  = 1'b1;
        addr0 = 12'h050;
        addr1 = 12'h060;
        #1;
        chk("mid_gnt0", 32'(gnt0_c), 32'd1);
        step();
        step();
        rst = 1'b1;
        #1;
        chk("mid_busy", 32'(busy_c), 32'd0);
        chk("mid_gnt", 32'({gnt0_c, gnt1_c}), 32'd0);
        chk("mid_rom_addr", 32'(rom_addr_c), 32'd0);
        chk("mid_rdata", rdata_c, 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("mid_norv_%0d", i), 32'({rvalid0_c, rvalid1_c}), 32'd0);
        end
        rst = 1'b0;
        #1;
        chk("mid_tie_gnt0", 32'(gnt0_c), 32'd1);
        chk("mid_tie_gnt1", 32'(gnt1_c), 32'd0);
        step();
        req0 = 1'b0;
        req1 = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("mid_after_rv0", 32'(rvalid0_c), 32'd1);
        chk("mid_after_rdata", rdata_c, 32'hC0DE_0050);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single combinational instruction ROM (12-bit word address, 32-bit data) between two requesters: port 0 = instruction fetch, port 1 = data-side constant/load reads.
- Arbitrates round-robin and sequences each access through a programmable number of wait cycles, so slower ROM implementations (block RAM, flash shim) can sit behind it.
- Returns registered read data with per-port valid, plus an out-of-range error flag.
- Sits between the core's fetch/LSU ports and the ROM contents module in the MCU memory subsystem.

Parameters:
- ADDR_W, 12, word-address width of requester and ROM address.
- DATA_W, 32, ROM data width.
- DEPTH, 4096, number of implemented ROM words; addresses >= DEPTH are out of range.
- RD_WAIT, 0, extra wait cycles per access (0..7).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- req0  in  1  port 0 request; held with addr0 until gnt0.
- addr0  in  ADDR_W  port 0 word address.
- flush0  in  1  cancels port 0's in-flight response (branch redirect).
- gnt0  out  1  port 0 request accepted this cycle.
- rvalid0  out  1  one-cycle pulse: rdata/rerr belong to port 0.
- req1  in  1  port 1 request.
- addr1  in  ADDR_W  port 1 word address.
- gnt1  out  1  port 1 request accepted this cycle.
- rvalid1  out  1  one-cycle pulse: rdata/rerr belong to port 1.
- rdata  out  DATA_W  registered read data, shared by both ports.
- rerr  out  1  registered; set with rvalid when the address was >= DEPTH.
- busy  out  1  high while state is not IDLE.
- rom_addr  out  ADDR_W  drives the ROM Address input.
- rom_data  in  DATA_W  ROM Data output (combinational).

Behaviour:
- Reset values:
  - gnt0/gnt1 = 0 (gated by Reset).
  - rvalid0/rvalid1 = 0, rerr = 0, rdata = 0, rom_addr = 0, busy = 0.
  - State IDLE; last-granted pointer = 1, so port 0 wins the first tie.
- IDLE:
  - gntX is combinational from reqX and the arbiter, and only one gnt is high at a time.
  - Only req0: grant 0. Only req1: grant 1.
  - Both requests: grant the port not equal to the last-granted pointer.
  - On a grant, at the clock edge: addr_q <= addrX, owner <= X, last <= X, cnt <= RD_WAIT, state <= READ.
- READ:
  - rom_addr = addr_q; no grants are issued.
  - If cnt != 0: cnt decrements.
  - If cnt == 0, at the edge:
    - If addr_q < DEPTH: rdata <= rom_data, rerr <= 0.
    - Otherwise: rdata <= 0, rerr <= 1.
    - rvalid_owner <= 1 and state <= IDLE.
- Latency: grant in cycle T, rvalid/rdata visible in cycle T+2+RD_WAIT.
- Throughput: the next grant is possible in cycle T+2+RD_WAIT, the same cycle rvalid is high.
- rvalidX is high for exactly one cycle. rdata and rerr hold their values until the next capture.
- flush0:
  - If flush0 is high in any cycle from the grant cycle through the capture cycle of a port-0 access, rvalid0 is suppressed for that access.
  - The access still runs to completion (timing unchanged) and rdata is still updated.
  - flush0 has no effect on port 1 accesses. flush0 in IDLE with no port-0 grant is ignored.
- Requesters may drop req without a grant; nothing is latched.
- A request arriving during READ waits; it is arbitrated in the next IDLE cycle.
- rom_addr holds addr_q after returning to IDLE until the next grant.
- Reset asserted mid-access: immediate return to reset values, and no rvalid is produced for the aborted access.
- Width rules:
  - Address compare is unsigned over ADDR_W.
  - When DEPTH = 2^ADDR_W, rerr is never set.
  - cnt is 3 bits wide.

Decomposition:
- Package rom_arb_pkg:
  - State encoding (IDLE, READ).
  - Port ID constants (PORT_FETCH = 0, PORT_DATA = 1).
  - Default ADDR_W/DATA_W.
- Sub-module rr_arbiter2:
  - Inputs: req[1:0], last.
  - Outputs: one-hot gnt[1:0] and the winner index.
  - Purely combinational. The pointer register stays in the parent.

Test Plan:
- Single fetch, RD_WAIT=0: req0=1, addr0=0x010, ROM[0x010]=0x00500093 at T → gnt0 at T; rvalid0=1, rdata=0x00500093, rerr=0 at T+2; rvalid1 stays 0.
- Tie after reset: req0 and req1 both held high → grants alternate 0,1,0,1, one every 2 cycles; each rvalid matches the owner's address data.
- Wait states, RD_WAIT=3: req1, addr1=0x7FF → busy high for 4 cycles; rvalid1 at T+5 with ROM[0x7FF].
- Out of range, DEPTH=1024: req1, addr1=0x400 → rvalid1 with rdata=0, rerr=1. A following request to addr 0x3FF → rerr=0.
- Flush: grant port 0, pulse flush0 at T+1 → no rvalid0 at T+2, busy drops normally. Port 1 requesting concurrently is granted at T+2 and is unaffected.
- Reset mid-READ (RD_WAIT=5): Reset asserted at T+2 → all outputs 0 immediately, no rvalid. After release, port 0 wins a tie.
